// File: rtl/rca_seq_adder_if.sv
// Handshake and data bundle for rca_seq_adder.
// The optional ovf flag exists only when RCA_SEQ_OVF_EN is defined.
interface rca_seq_adder_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             co;
`ifdef RCA_SEQ_OVF_EN
  logic             ovf;

  modport master (output start, a, b, ci, input busy, done, s, co, ovf);
  modport slave  (input start, a, b, ci, output busy, done, s, co, ovf);
`else
  modport master (output start, a, b, ci, input busy, done, s, co);
  modport slave  (input start, a, b, ci, output busy, done, s, co);
`endif
endinterface

// File: rtl/rca_seq_adder.sv
// Multi-cycle WIDTH-bit adder that steps one shared 4-bit ripple-carry adder LSB->MSB.
// Optional macro RCA_SEQ_OVF_EN adds a registered two's-complement overflow flag (bus.ovf).
module rca_seq_adder_rca4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       ci_i,
  output logic [3:0] s_o,
  output logic       co_o
);
  logic c;
  always_comb begin
    c = ci_i;
    s_o = '0;
    for (int i = 0; i < 4; i++) begin
      s_o[i] = a_i[i] ^ b_i[i] ^ c;
      c      = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
    end
    co_o = c;
  end
endmodule

module rca_seq_adder #(
  parameter int WIDTH = 16
) (
  input  logic           clk,
  input  logic           reset,
  rca_seq_adder_if.slave bus
);
  localparam int NIB   = WIDTH / 4;
  localparam int IDX_W = $clog2(NIB);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [IDX_W-1:0] idx_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_l_q;
  logic [WIDTH-1:0] b_l_q;
  logic [WIDTH-1:0] s_q;
  logic             co_q;
  logic             busy_q;
  logic             done_q;

  // Bit offset of the active nibble.
  logic [IDX_W+1:0] base;
  logic [3:0]       rca_s;
  logic             rca_co;

  assign base = {idx_q, 2'b00};

  rca_seq_adder_rca4 u_rca (
    .a_i  (a_l_q[base +: 4]),
    .b_i  (b_l_q[base +: 4]),
    .ci_i (carry_q),
    .s_o  (rca_s),
    .co_o (rca_co)
  );

`ifdef RCA_SEQ_OVF_EN
  logic ovf_q;
  assign bus.ovf = ovf_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_l_q   <= '0;
      b_l_q   <= '0;
      s_q     <= '0;
      co_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef RCA_SEQ_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_l_q   <= bus.a;
            b_l_q   <= bus.b;
            carry_q <= bus.ci;
            idx_q   <= '0;
            s_q     <= '0;
            co_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= RUN;
`ifdef RCA_SEQ_OVF_EN
            ovf_q   <= 1'b0;
`endif
          end
        end
        RUN: begin
          s_q[base +: 4] <= rca_s;
          carry_q        <= rca_co;
          idx_q          <= idx_q + 1'b1;
          if (idx_q == IDX_W'(NIB - 1)) begin
            co_q    <= rca_co;
            done_q  <= 1'b1;
            state_q <= DONE;
`ifdef RCA_SEQ_OVF_EN
            // Sign of the fresh MSB nibble result decides overflow; ci is not considered.
            ovf_q   <= (a_l_q[WIDTH-1] == b_l_q[WIDTH-1]) && (rca_s[3] != a_l_q[WIDTH-1]);
`endif
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.s    = s_q;
  assign bus.co   = co_q;
endmodule

// File: tb/tb_rca_seq_adder.sv
// Directed-vector bench for rca_seq_adder (WIDTH=16); ovf checks apply when RCA_SEQ_OVF_EN is defined.
module tb_rca_seq_adder;
  localparam int W = 16;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  rca_seq_adder_if #(.WIDTH(W)) bus ();

  rca_seq_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic [W-1:0] exp_s;
    logic         exp_co;
    logic         exp_ovf;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_ovf(input string name, input logic exp);
`ifdef RCA_SEQ_OVF_EN
    check(name, 32'(bus.ovf), 32'(exp));
`else
    if (exp === 1'bx) $display("unreachable %s", name);
`endif
  endtask

  // Issue one op with a single-cycle start pulse and check timing and result.
  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ci, input logic [W-1:0] es, input logic eco, input logic eovf);
    int cyc;
    int busy_cnt;
    @(negedge clk);
    bus.start = 1'b1; bus.a = a; bus.b = b; bus.ci = ci;
    cyc = 0; busy_cnt = 0;
    do begin
      @(negedge clk);
      bus.start = 1'b0;
      cyc++;
      if (bus.busy) busy_cnt++;
    end while (!bus.done && cyc < 20);
    check({name, " latency"}, 32'(cyc), 32'd5);
    check({name, " s"}, 32'(bus.s), 32'(es));
    check({name, " co"}, 32'(bus.co), 32'(eco));
    check_ovf({name, " ovf"}, eovf);
    @(negedge clk);
    check({name, " busy cycles"}, 32'(busy_cnt + int'(bus.busy)), 32'd5);
    check({name, " done pulse"}, 32'(bus.done), 32'd0);
    check({name, " s hold"}, 32'(bus.s), 32'(es));
    $display("op %s: %h + %h + %0d -> s=%h co=%0d", name, a, b, ci, bus.s, bus.co);
  endtask

  initial begin
    int t_first;
    int t_second;
    int n_done;
    int cyc;

    vecs[0] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[2] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
    vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[5] = '{16'h0001, 16'hFFFF, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[6] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};
    vecs[7] = '{16'hABCD, 16'h1234, 1'b1, 16'hBE02, 1'b0, 1'b0};
    vecs[8] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[9] = '{16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0};

    reset = 1'b1;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.ci = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("reset busy", 32'(bus.busy), 32'd0);
      check("reset done", 32'(bus.done), 32'd0);
      check("reset s", 32'(bus.s), 32'd0);
      check("reset co", 32'(bus.co), 32'd0);
      check_ovf("reset ovf", 1'b0);
    end

    for (int i = 0; i < 10; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].ci,
             vecs[i].exp_s, vecs[i].exp_co, vecs[i].exp_ovf);
    end

    // Operand changes and a second start during RUN must be ignored.
    @(negedge clk);
    bus.start = 1'b1; bus.a = 16'h1234; bus.b = 16'h1111; bus.ci = 1'b0;
    @(negedge clk);
    bus.a = 16'hFFFF; bus.b = 16'hFFFF; bus.ci = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n_done = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.done) begin
        n_done++;
        check("ignore s", 32'(bus.s), 32'h2345);
        check("ignore co", 32'(bus.co), 32'd0);
      end
    end
    check("ignore done count", 32'(n_done), 32'd1);
    $display("op ignore-while-busy: dones=%0d s=%h", n_done, bus.s);

    // Reset on the second RUN cycle discards the op.
    @(negedge clk);
    bus.start = 1'b1; bus.a = 16'hAAAA; bus.b = 16'h5555; bus.ci = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset s", 32'(bus.s), 32'd0);
    check("midreset busy", 32'(bus.busy), 32'd0);
    check("midreset done", 32'(bus.done), 32'd0);
    check("midreset co", 32'(bus.co), 32'd0);
    $display("op mid-run reset: s=%h busy=%0d", bus.s, bus.busy);
    run_op("after-reset", 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0);

    // Start held high: back-to-back ops every NIB+2 cycles.
    @(negedge clk);
    bus.start = 1'b1; bus.a = 16'h0001; bus.b = 16'h0002; bus.ci = 1'b0;
    t_first = -1; t_second = -1; cyc = 0;
    while (t_second < 0 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (bus.done) begin
        check("b2b s", 32'(bus.s), 32'h0003);
        if (t_first < 0) t_first = cyc;
        else t_second = cyc;
      end
    end
    bus.start = 1'b0;
    check("b2b first done", 32'(t_first), 32'd5);
    check("b2b spacing", 32'(t_second - t_first), 32'd6);
    $display("op back-to-back: dones at %0d and %0d", t_first, t_second);
    repeat (3) @(negedge clk);
    check("b2b idle busy", 32'(bus.busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
